store_write_unit: RTL

- Data-memory write stage downstream of the store-width decoder.
- Consumes the 2-bit save method (00 byte, 01 half, 10 word, 11 reserved), byte address and store data.
- Drives byte-enabled, word-aligned write requests to data memory with a req/ack handshake.
- Splits stores that cross a word boundary into two word writes; stalls the pipeline until the write completes.

---
 rtl/store_write_unit.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/store_write_unit.sv
// ---------------------------------------------------------------------------
// store_write_unit
//
// Data-memory write stage that follows the store-width decoder. It takes one
// store (width code, byte address, LSB-justified data), positions the bytes
// into their memory lanes, and issues word-aligned, byte-enabled write
// requests over a req/ack handshake. A store that straddles a word boundary
// becomes two word writes (LO word, then HI word). The pipeline is stalled
// (store_ready low) until the store completes, aborts or traps.
//
// Parameters:
//   ADDR_W   byte-address width
//   TIMEOUT  cycles a request may wait for mem_ack before aborting (>= 2)
//
// Optional build macro:
//   STORE_MISALIGN_TRAP_EN  when defined, word-crossing stores are not split
//                           but finish immediately with store_err.
//
// Ports:
//   clk, rst          clock (posedge), asynchronous active-high reset
//   store_valid       store request from the pipeline
//   save_method[1:0]  00 byte, 01 half, 10 word, 11 reserved
//   addr              byte address
//   wdata[31:0]       store data, LSB-justified
//   store_ready       unit idle and able to accept (low = stall)
//   store_done        one-cycle completion pulse
//   store_err         with store_done: reserved code, timeout or trap
//   mem_req           write request (registered)
//   mem_addr          word-aligned write address (registered)
//   mem_wdata[31:0]   lane-positioned write data (registered)
//   mem_be[3:0]       byte enables (registered)
//   mem_ack           memory accepted the write (sampled while mem_req=1)
// ---------------------------------------------------------------------------
module store_write_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              store_valid,
   input  logic [1:0]        save_method,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              store_ready,
   output logic              store_done,
   output logic              store_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_FIN
   } state_t;

   state_t r_state;
   state_t w_stateNext;

   logic [1:0]        r_method;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_err;
   logic [CNT_W-1:0]  r_tmoCnt;
   logic              r_memReq;
   logic [ADDR_W-1:0] r_memAddr;
   logic [31:0]       r_memWdata;
   logic [3:0]        r_memBe;

   logic              w_accept;
   logic [1:0]        w_srcMethod;
   logic [ADDR_W-1:0] w_srcAddr;
   logic [31:0]       w_srcWdata;
   logic [1:0]        w_off;
   logic [3:0]        w_mask;
   logic [31:0]       w_masked;
   logic [7:0]        w_be8;
   logic [63:0]       w_data64;
   logic [ADDR_W-1:0] w_loAddr;
   logic [ADDR_W-1:0] w_hiAddr;
   logic              w_reserved;
   logic              w_split;
   logic              w_timeoutHit;
   logic              w_errNext;
   logic [CNT_W-1:0]  w_cntNext;

   assign w_accept    = store_valid && (r_state == S_IDLE);
   assign store_ready = (r_state == S_IDLE);
   assign store_done  = (r_state == S_FIN);
   assign store_err   = (r_state == S_FIN) && r_err;
   assign mem_req     = r_memReq;
   assign mem_addr    = r_memAddr;
   assign mem_wdata   = r_memWdata;
   assign mem_be      = r_memBe;

   // While idle the lane math looks straight at the inputs so the first
   // request can be registered on the accept edge; once busy it uses the
   // latched copy, which keeps the request fields stable.
   assign w_srcMethod = (r_state == S_IDLE) ? save_method : r_method;
   assign w_srcAddr   = (r_state == S_IDLE) ? addr        : r_addr;
   assign w_srcWdata  = (r_state == S_IDLE) ? wdata       : r_wdata;

   // Byte lane placement: the store is viewed as an 8-byte window starting at
   // the word address; the low half is the LO write, the high half the HI one.
   always_comb begin
      w_mask   = 4'b0000;
      w_masked = 32'h0;
      case (w_srcMethod)
         2'b00: begin
            w_mask   = 4'b0001;
            w_masked = {24'h0, w_srcWdata[7:0]};
         end
         2'b01: begin
            w_mask   = 4'b0011;
            w_masked = {16'h0, w_srcWdata[15:0]};
         end
         2'b10: begin
            w_mask   = 4'b1111;
            w_masked = w_srcWdata;
         end
         default: begin
            w_mask   = 4'b0000;
            w_masked = 32'h0;
         end
      endcase
   end

   assign w_off        = w_srcAddr[1:0];
   assign w_be8        = {4'b0000, w_mask} << w_off;
   assign w_data64     = {32'h0, w_masked} << {w_off, 3'b000};
   assign w_loAddr     = {w_srcAddr[ADDR_W-1:2], 2'b00};
   assign w_hiAddr     = w_loAddr + {{(ADDR_W-3){1'b0}}, 3'b100};
   assign w_reserved   = (w_srcMethod == 2'b11);
   assign w_split      = (w_be8[7:4] != 4'b0000);
   assign w_timeoutHit = (r_tmoCnt == TMO_LAST);

   // Next-state, error and timeout-counter decisions. The counter is cleared
   // whenever the state changes, so it restarts for each LO/HI request.
   always_comb begin
      w_stateNext = r_state;
      w_errNext   = r_err;
      w_cntNext   = r_tmoCnt;
      case (r_state)
         S_IDLE: begin
            if (store_valid) begin
               w_errNext = 1'b0;
               if (w_reserved) begin
                  w_stateNext = S_FIN;
                  w_errNext   = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
               end else if (w_split) begin
                  w_stateNext = S_FIN;
                  w_errNext   = 1'b1;
`endif
               end else begin
                  w_stateNext = S_LO;
               end
            end
         end
         S_LO: begin
            if (mem_ack) begin
               w_stateNext = w_split ? S_HI : S_FIN;
            end else if (w_timeoutHit) begin
               w_stateNext = S_FIN;
               w_errNext   = 1'b1;
            end
         end
         S_HI: begin
            if (mem_ack) begin
               w_stateNext = S_FIN;
            end else if (w_timeoutHit) begin
               w_stateNext = S_FIN;
               w_errNext   = 1'b1;
            end
         end
         S_FIN: begin
            w_stateNext = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
      if (w_stateNext != r_state) begin
         w_cntNext = '0;
      end else if (r_memReq && !mem_ack) begin
         w_cntNext = r_tmoCnt + 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Latched store, error flag, timeout counter and the registered memory
   // request. The request fields follow the state being entered, so they are
   // zero outside LO/HI and change only on a LO->HI step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_method   <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_err      <= 1'b0;
         r_tmoCnt   <= '0;
         r_memReq   <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= 32'h0;
         r_memBe    <= 4'b0000;
      end else begin
         if (w_accept) begin
            r_method <= save_method;
            r_addr   <= addr;
            r_wdata  <= wdata;
         end
         r_err    <= w_errNext;
         r_tmoCnt <= w_cntNext;
         case (w_stateNext)
            S_LO: begin
               r_memReq   <= 1'b1;
               r_memAddr  <= w_loAddr;
               r_memWdata <= w_data64[31:0];
               r_memBe    <= w_be8[3:0];
            end
            S_HI: begin
               r_memReq   <= 1'b1;
               r_memAddr  <= w_hiAddr;
               r_memWdata <= w_data64[63:32];
               r_memBe    <= w_be8[7:4];
            end
            default: begin
               r_memReq   <= 1'b0;
               r_memAddr  <= '0;
               r_memWdata <= 32'h0;
               r_memBe    <= 4'b0000;
            end
         endcase
      end
   end

endmodule
